sine_period_meter: RTL and testbench
====================================

Name: sine_period_meter

Overview:
Measures the waveform produced by the sine ROM lookup. It consumes the WIDTH-bit offset-binary sample stream at the sample-enable rate. It detects rising mid-scale crossings with hysteresis and reports the period in samples and the peak-to-peak amplitude of each completed cycle. It is used on the lab bench path to check the generated tone frequency and amplitude, and to flag loss of signal.

Parameters:
WIDTH, 8, bit width of input samples and of the pk_pk output; mid-scale MID = 2^(WIDTH-1).
COUNT_WIDTH, 24, width of the sample counter and the period output.
HYST, 4, hysteresis in LSBs around MID; legal range 0 .. 2^(WIDTH-1)-1.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  sample strobe; sine is accepted only on edges where enable=1.
sine  input  WIDTH  unsigned offset-binary sample.
period  output  COUNT_WIDTH  samples per last completed cycle (registered).
pk_pk  output  WIDTH  max minus min over last completed cycle (registered).
valid  output  1  one-cycle pulse: period/pk_pk just updated.
no_signal  output  1  level; counter saturated without a rising crossing.

Behaviour:
- Reset (synchronous, active-high; wins over enable): period=0, pk_pk=0, valid=0, no_signal=0, state=IDLE, below=0, cnt=0, max=0, min=all-ones.
- Thresholds: HI = MID+HYST, LO = MID-HYST. Compute in WIDTH+1 bits, then truncate; the legal HYST range guarantees no overflow.
- The crossing detector operates on accepted samples only:
  - sample <= LO sets below=1.
  - A rising event is an accepted sample with sample >= HI while below=1; it clears below.
  - Samples strictly between LO and HI change nothing. Noise inside the band produces no events.
- cnt saturates at 2^COUNT_WIDTH-1.
  - On an event sample: cnt <= 1.
  - On any other accepted sample: cnt <= cnt+1.
  - Hence a waveform of N samples per cycle yields cnt=N at the next event.
- max/min track accepted samples. On an event sample, both are reloaded with that sample, so it belongs to the new cycle.
- States:
  - IDLE: waiting for the first rising event. Event -> MEASURE; no valid issued.
  - MEASURE: on an event, period <= cnt, pk_pk <= max-min (over the closed cycle, which excludes the current sample), valid <= 1, no_signal <= 0; remain in MEASURE.
  - Timeout: cnt reaching saturation in either state -> no_signal <= 1, state <= IDLE, cnt <= 0. period and pk_pk hold their last values.
- Latency: outputs update on the same edge that accepts the event sample and are visible the following cycle. valid is high exactly one cycle, then 0. The first valid after reset or timeout requires two rising events.
- enable=0 cycles: all state holds; valid is still forced to 0.
- reset asserted mid-cycle discards the partial measurement.

Decomposition:
- Package sine_meter_pkg:
  - state enum typedef {IDLE, MEASURE};
  - function thresholds(WIDTH, HYST) returning HI/LO.
- Sub-module sine_crossing_detect:
  - holds the registered below flag;
  - inputs: clk, reset, enable, sine;
  - output: combinational rise_event for the current accepted sample.
- The top level holds the counter, the min/max registers, the FSM and the output registers.

Test Plan:
1. Reset check: hold reset 3 cycles with enable=1 and random sine -> period=0, pk_pk=0, valid=0, no_signal=0 throughout and on the cycle after release.
2. Steady square wave, WIDTH=8, HYST=4, enable every cycle: repeat 20 samples at 200 then 20 at 50.
   - No valid at the first rising edge.
   - At each later rising edge: valid for one cycle, period=40, pk_pk=150.
3. Enable gating: same sequence with enable every 4th cycle -> period=40, pk_pk=150; valid pulses 160 clk apart; cycles with enable=0 leave outputs and counter unchanged.
4. Hysteresis band: samples cycling 126,128,130,128, with COUNT_WIDTH=8 -> never a valid. no_signal=1 once cnt hits 255; period and pk_pk hold.
5. Recovery after timeout: after step 4, apply the square wave from step 2 -> no_signal stays 1 until the second rising event, then valid, period=40, pk_pk=150, no_signal=0.
6. Reset mid-cycle: during the steady wave, pulse reset 1 cycle 10 samples after a rising event -> outputs return to reset values. The first subsequent valid occurs only at the second rising event after reset, with period=40.

Source files
------------

// File: rtl/sine_meter_pkg.sv
// Shared types and helpers for the sine period/amplitude meter.
package sine_meter_pkg;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } thresh_t;

  // Hysteresis thresholds around mid-scale; callers truncate to the sample width.
  function automatic thresh_t thresholds(input int unsigned width, input int unsigned hyst);
    thresh_t     t;
    logic [32:0] mid;
    mid  = 33'd1 << (width - 1);
    t.hi = 32'(mid + 33'(hyst));
    t.lo = 32'(mid - 33'(hyst));
    return t;
  endfunction

endpackage

// File: rtl/sine_period_meter_detect.sv
// Rising mid-scale crossing detector with hysteresis on accepted samples.
module sine_crossing_detect
  import sine_meter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned HYST  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] sine,
  output logic             rise_event
);

  localparam thresh_t          TH = thresholds(WIDTH, HYST);
  localparam logic [WIDTH-1:0] HI = TH.hi[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LO = TH.lo[WIDTH-1:0];

  logic below;

  assign rise_event = enable && below && (sine >= HI);

  // Arm on a low sample, disarm on the rising event; in-band samples hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      below <= 1'b0;
    end else if (enable) begin
      if (rise_event) begin
        below <= 1'b0;
      end else if (sine <= LO) begin
        below <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sine_period_meter.sv
// Period and peak-to-peak meter for the offset-binary sine sample stream.
module sine_period_meter
  import sine_meter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned COUNT_WIDTH = 24,
  parameter int unsigned HYST        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [WIDTH-1:0]       sine,
  output logic [COUNT_WIDTH-1:0] period,
  output logic [WIDTH-1:0]       pk_pk,
  output logic                   valid,
  output logic                   no_signal
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]       max_q, max_d;
  logic [WIDTH-1:0]       min_q, min_d;
  logic [COUNT_WIDTH-1:0] period_d;
  logic [WIDTH-1:0]       pk_pk_d;
  logic                   valid_d;
  logic                   no_signal_d;
  logic                   rise_event;

  sine_crossing_detect #(
    .WIDTH (WIDTH),
    .HYST  (HYST)
  ) u_detect (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sine       (sine),
    .rise_event (rise_event)
  );

  // State, counter, extrema and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      max_q     <= '0;
      min_q     <= '1;
      period    <= '0;
      pk_pk     <= '0;
      valid     <= 1'b0;
      no_signal <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      min_q     <= min_d;
      period    <= period_d;
      pk_pk     <= pk_pk_d;
      valid     <= valid_d;
      no_signal <= no_signal_d;
    end
  end

  // Next-state: close a cycle on a rising event, otherwise count/track or time out.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    max_d       = max_q;
    min_d       = min_q;
    period_d    = period;
    pk_pk_d     = pk_pk;
    valid_d     = 1'b0;
    no_signal_d = no_signal;

    if (enable) begin
      if (rise_event) begin
        // The event sample opens the new cycle, so the closed cycle's stats use the old registers.
        cnt_d   = CNT_ONE;
        max_d   = sine;
        min_d   = sine;
        state_d = MEASURE;
        if (state_q == MEASURE) begin
          period_d    = cnt_q;
          pk_pk_d     = max_q - min_q;
          valid_d     = 1'b1;
          no_signal_d = 1'b0;
        end
      end else begin
        if (sine > max_q) max_d = sine;
        if (sine < min_q) min_d = sine;
        if (cnt_q == '1) begin
          no_signal_d = 1'b1;
          state_d     = IDLE;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sine_period_meter.sv
// Self-checking bench: table-driven square waves plus hand-written timeout/reset sequences.
module tb_sine_period_meter;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [W-1:0]  sine;
  logic [CW-1:0] period;
  logic [W-1:0]  pk_pk;
  logic          valid;
  logic          no_signal;

  always #5 clk = ~clk;

  sine_period_meter #(
    .WIDTH       (W),
    .COUNT_WIDTH (CW),
    .HYST        (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .sine      (sine),
    .period    (period),
    .pk_pk     (pk_pk),
    .valid     (valid),
    .no_signal (no_signal)
  );

  typedef struct {
    logic [CW-1:0] period;
    logic [W-1:0]  pk;
  } exp_t;

  typedef struct {
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    int            half;
    int            spacing;
    int            cycles;
    bit            crosses;
    logic [CW-1:0] period;
    logic [W-1:0]  pk;
    int            gap;
  } row_t;

  exp_t exp_q[$];
  row_t rows[6];
  row_t r;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int valids_seen   = 0;
  int last_valid_cyc = -1;
  int exp_gap = 0;
  bit prev_valid = 1'b0;
  logic [W-1:0] band[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic observe();
    exp_t e;
    if (valid === 1'b1) begin
      valids_seen++;
      chk("valid_pulse_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_valid", {31'd0, valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("period", 32'(period), 32'(e.period));
        chk("pk_pk", 32'(pk_pk), 32'(e.pk));
        chk("no_signal_at_valid", {31'd0, no_signal}, 32'd0);
      end
      if (exp_gap != 0 && last_valid_cyc >= 0)
        chk("valid_gap", 32'(cyc - last_valid_cyc), 32'(exp_gap));
      last_valid_cyc = cyc;
    end
    prev_valid = valid;
  endtask

  task automatic step(input logic rst, input logic en, input logic [W-1:0] s);
    logic [CW-1:0] p0;
    logic [W-1:0]  k0;
    p0 = period;
    k0 = pk_pk;
    reset  = rst;
    enable = en;
    sine   = s;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!rst && !en) begin
      chk("gated_valid", {31'd0, valid}, 32'd0);
      chk("gated_hold", 32'({period, pk_pk}), 32'({p0, k0}));
    end
    observe();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_period"}, 32'(period), 32'd0);
    chk({tag, "_pk_pk"}, 32'(pk_pk), 32'd0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_no_signal"}, {31'd0, no_signal}, 32'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, W'($urandom_range(255)));
  endtask

  task automatic begin_phase(input int gap);
    exp_gap        = gap;
    last_valid_cyc = -1;
    valids_seen    = 0;
  endtask

  // Square wave starting with the high half; a valid is expected at cycle c >= first_valid.
  task automatic square(input row_t rw, input int first_valid);
    exp_t e;
    logic [W-1:0] s;
    for (int c = 1; c <= rw.cycles; c++) begin
      for (int i = 0; i < 2 * rw.half; i++) begin
        s = (i < rw.half) ? rw.hi : rw.lo;
        if (i == 0 && rw.crosses && c >= first_valid) begin
          e.period = rw.period;
          e.pk     = rw.pk;
          exp_q.push_back(e);
        end
        step(1'b0, 1'b1, s);
        for (int k = 1; k < rw.spacing; k++)
          step(1'b0, 1'b0, W'($urandom_range(255)));
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset  = 1'b1;
    enable = 1'b0;
    sine   = '0;
    band[0] = 8'd126; band[1] = 8'd128; band[2] = 8'd130; band[3] = 8'd128;

    //            hi   lo  half sp cyc x  period pk  gap
    rows[0] = '{8'd200, 8'd50,  20, 1, 4, 1'b1, 8'd40, 8'd150, 40};
    rows[1] = '{8'd132, 8'd124,  5, 1, 4, 1'b1, 8'd10, 8'd8,   10};
    rows[2] = '{8'd180, 8'd100, 10, 4, 4, 1'b1, 8'd20, 8'd80,  80};
    rows[3] = '{8'd131, 8'd124,  5, 1, 4, 1'b0, 8'd0,  8'd0,    0};
    rows[4] = '{8'd132, 8'd125,  5, 1, 4, 1'b0, 8'd0,  8'd0,    0};
    rows[5] = '{8'd200, 8'd50,  20, 4, 3, 1'b1, 8'd40, 8'd150, 160};

    // Reset held with enable and random samples, then released.
    for (int i = 0; i < 3; i++) begin
      do_reset();
      check_reset_outputs("reset_hold");
    end
    step(1'b0, 1'b1, 8'd128);
    check_reset_outputs("reset_release");

    // Table of square waves: amplitudes, threshold boundaries, enable gating.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      begin_phase(rows[t].gap);
      square(rows[t], 3);
      chk("valid_count", 32'(valids_seen), rows[t].crosses ? 32'(rows[t].cycles - 2) : 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      if (!rows[t].crosses) begin
        chk("nocross_period", 32'(period), 32'd0);
        chk("nocross_pk_pk", 32'(pk_pk), 32'd0);
      end
    end

    // In-band noise until timeout; last measurement must hold.
    do_reset();
    begin_phase(40);
    square(rows[0], 3);
    begin_phase(0);
    n = 0;
    while (no_signal !== 1'b1 && n < 400) begin
      step(1'b0, 1'b1, band[n % 4]);
      n++;
    end
    chk("timeout_reached", {31'd0, no_signal}, 32'd1);
    chk("timeout_window", {31'd0, (n >= 214 && n <= 217)}, 32'd1);
    chk("band_valids", 32'(valids_seen), 32'd0);
    chk("hold_period", 32'(period), 32'd40);
    chk("hold_pk_pk", 32'(pk_pk), 32'd150);

    // Recovery: first event only re-arms, second one reports.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'd200);
    chk("recover_no_signal_held", {31'd0, no_signal}, 32'd1);
    chk("recover_no_early_valid", 32'(valids_seen), 32'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'd50);
    begin_phase(40);
    r = rows[0];
    r.cycles = 2;
    square(r, 1);
    chk("recover_valids", 32'(valids_seen), 32'd2);
    chk("recover_no_signal_clear", {31'd0, no_signal}, 32'd0);

    // Reset 10 samples into a cycle discards the partial measurement.
    begin_phase(0);
    begin
      exp_t e;
      e.period = 8'd40;
      e.pk     = 8'd150;
      exp_q.push_back(e);
    end
    step(1'b0, 1'b1, 8'd200);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'd200);
    step(1'b1, 1'b1, 8'd200);
    check_reset_outputs("mid_reset");
    begin_phase(40);
    square(rows[0], 3);
    chk("post_reset_valids", 32'(valids_seen), 32'd2);
    chk("post_reset_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
